// File: rtl/agc_loop_if.sv
// Sample stream from the ADC into the AGC: signed I/Q pair plus a valid strobe.
interface agc_loop_if #(
    parameter int D_WID = 10
);
    logic signed [D_WID-1:0] data_i_in;
    logic signed [D_WID-1:0] data_q_in;
    logic                    data_vld;

    modport master (output data_i_in, output data_q_in, output data_vld);
    modport slave  (input  data_i_in, input  data_q_in, input  data_vld);
endinterface

// File: rtl/agc_loop.sv
// Closed-loop AGC: windowed I/Q power estimate in a log2 domain, a stepping
// threshold loop with dead band and lock detection, and the gain PWM.
module agc_loop #(
    parameter int D_WID    = 10,
    parameter int PWM_W    = 7,
    parameter int TH_INIT  = 64,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    agc_loop_if.slave        smp,
    input  logic             agc_en,
    input  logic [1:0]       pwr_est_prd,
    input  logic [7:0]       pwr_target,
    input  logic [3:0]       pwr_tol,
    input  logic [1:0]       pwm_step,
    input  logic             pwm_inv,
    input  logic             pwm_th_ena,
    input  logic [PWM_W-1:0] pwm_th_in,
    input  logic [PWM_W-1:0] pwm_max_val,
    output logic [7:0]       pwr_est_val,
    output logic             pwr_est_end,
    output logic             agc_fix,
    output logic [PWM_W-1:0] pwm_th_out,
    output logic             pwm_out
);
    localparam int P_W   = 2 * D_WID;
    localparam int ACC_W = 2 * D_WID + 12;
    localparam int TH_W  = PWM_W + 1;
    localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic signed [D_WID-1:0] r_i, r_q;
    logic                    r_s0_vld;
    logic [P_W-1:0]          r_p;
    logic                    r_s1_vld;
    logic [ACC_W-1:0]        r_acc;
    logic [11:0]             r_smp_cnt;
    logic [1:0]              r_prd;
    logic [ACC_W-1:0]        r_avg;
    logic                    r_avg_vld;
    logic [7:0]              r_est_val;
    logic                    r_est_end;
    logic [PWM_W-1:0]        r_th;
    logic [3:0]              r_lock;
    logic                    r_fix;
    logic [PWM_W-1:0]        r_cnt;
    logic [PWM_W-1:0]        r_th_act;
    logic                    r_pwm;

    logic signed [P_W-1:0]   w_ii, w_qq;
    logic [P_W-1:0]          w_p;
    logic [1:0]              w_prd;
    logic [11:0]             w_win_max;
    logic [3:0]              w_shift;
    logic                    w_win_end;
    logic [ACC_W-1:0]        w_sum;
    logic [5:0]              w_k;
    logic [ACC_W+2:0]        w_scaled;
    logic [2:0]              w_m;
    logic [7:0]              w_est;
    logic [8:0]              w_hi_sum, w_lo_dif;
    logic [7:0]              w_hi, w_lo;
    logic [TH_W-1:0]         w_step, w_th_dn, w_th_up;
    logic [PWM_W-1:0]        w_th_dn_sat, w_th_up_sat, w_th_man;
    logic [3:0]              w_lock_nxt;

    // Squares cannot overflow: (-2^(D_WID-1))^2 * 2 = 2^(2*D_WID-1) fits P_W unsigned.
    assign w_ii  = r_i * r_i;
    assign w_qq  = r_q * r_q;
    assign w_p   = $unsigned(w_ii) + $unsigned(w_qq);
    assign w_sum = r_acc + ACC_W'(r_p);

    // Window length comes from the live input only on the first sample of a window.
    // NOTE: every signal driven in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        w_prd = (r_smp_cnt == '0) ? pwr_est_prd : r_prd;
        case (w_prd)
            2'd0:    w_win_max = 12'd63;
            2'd1:    w_win_max = 12'd255;
            2'd2:    w_win_max = 12'd1023;
            default: w_win_max = 12'd4095;
        endcase
        w_shift   = 4'd6 + {1'b0, w_prd, 1'b0};
        w_win_end = r_s1_vld && (r_smp_cnt == w_win_max);
    end

    // Log2 estimate: leading-one index k and the three bits below it.
    always_comb begin
        w_k = '0;
        for (int b = 0; b < ACC_W; b++) begin
            if (r_avg[b]) w_k = 6'(b);
        end
        w_scaled = {r_avg, 3'b000} >> w_k;
        w_m      = w_scaled[2:0];
        w_est    = (r_avg == '0) ? 8'd0 : {w_k[4:0], w_m};
    end

    // Dead band edges, step arithmetic and manual threshold limit.
    always_comb begin
        w_hi_sum    = {1'b0, pwr_target} + {5'b0, pwr_tol};
        w_lo_dif    = {1'b0, pwr_target} - {5'b0, pwr_tol};
        w_hi        = w_hi_sum[8] ? 8'hFF : w_hi_sum[7:0];
        w_lo        = w_lo_dif[8] ? 8'h00 : w_lo_dif[7:0];
        w_step      = TH_W'(1) << pwm_step;
        w_th_dn     = {1'b0, r_th} - w_step;
        w_th_up     = {1'b0, r_th} + w_step;
        w_th_dn_sat = w_th_dn[PWM_W] ? '0 : w_th_dn[PWM_W-1:0];
        w_th_up_sat = (w_th_up > {1'b0, pwm_max_val}) ? pwm_max_val : w_th_up[PWM_W-1:0];
        w_th_man    = (pwm_th_in > pwm_max_val) ? pwm_max_val : pwm_th_in;
        w_lock_nxt  = (r_lock >= 4'(LOCK_CNT)) ? r_lock : r_lock + 4'd1;
    end

    // Capture and square stages; a disabled loop drops anything in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i      <= '0;
            r_q      <= '0;
            r_s0_vld <= 1'b0;
            r_p      <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_i      <= smp.data_i_in;
            r_q      <= smp.data_q_in;
            r_s0_vld <= smp.data_vld & agc_en;
            r_p      <= w_p;
            r_s1_vld <= r_s0_vld & agc_en;
        end
    end

    // Accumulate valid samples; at window end hand the mean on and restart seamlessly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_smp_cnt <= '0;
            r_prd     <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else if (!agc_en) begin
            r_acc     <= '0;
            r_smp_cnt <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_avg_vld <= 1'b0;
            if (r_s1_vld) begin
                if (r_smp_cnt == '0) r_prd <= pwr_est_prd;
                if (w_win_end) begin
                    r_acc     <= '0;
                    r_smp_cnt <= '0;
                    r_avg     <= w_sum >> w_shift;
                    r_avg_vld <= 1'b1;
                end else begin
                    r_acc     <= w_sum;
                    r_smp_cnt <= r_smp_cnt + 12'd1;
                end
            end
        end
    end

    // Publish the log estimate together with its one-cycle strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_est_val <= '0;
            r_est_end <= 1'b0;
        end else begin
            r_est_end <= r_avg_vld & agc_en;
            if (r_avg_vld && agc_en) r_est_val <= w_est;
        end
    end

    // Threshold loop: manual override, hold when disabled, step on each estimate, clamp to ceiling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_th   <= PWM_W'(TH_INIT);
            r_lock <= '0;
            r_fix  <= 1'b0;
        end else if (pwm_th_ena) begin
            r_th   <= w_th_man;
            r_lock <= '0;
            r_fix  <= 1'b0;
        end else if (!agc_en) begin
            r_lock <= '0;
            r_fix  <= 1'b0;
            if (r_th > pwm_max_val) r_th <= pwm_max_val;
        end else if (r_est_end) begin
            if (r_est_val > w_hi) begin
                r_th   <= w_th_dn_sat;
                r_lock <= '0;
                r_fix  <= 1'b0;
            end else if (r_est_val < w_lo) begin
                r_th   <= w_th_up_sat;
                r_lock <= '0;
                r_fix  <= 1'b0;
            end else begin
                r_lock <= w_lock_nxt;
                r_fix  <= (w_lock_nxt >= 4'(LOCK_CNT));
            end
        end else if (r_th > pwm_max_val) begin
            r_th <= pwm_max_val;
        end
    end

    // PWM: threshold is adopted only at the period boundary so each period is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_th_act <= '0;
            r_pwm    <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < r_th_act) ^ pwm_inv;
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) r_th_act <= r_th;
        end
    end

    assign pwr_est_val = r_est_val;
    assign pwr_est_end = r_est_end;
    assign agc_fix     = r_fix;
    assign pwm_th_out  = r_th;
    assign pwm_out     = r_pwm;
endmodule

// File: tb/tb_agc_loop.sv
// Bench for agc_loop: directed steps plus randomized segments, every cycle
// compared against a sample-level reference model of the loop.
module tb_agc_loop;
    localparam int D_WID    = 10;
    localparam int PWM_W    = 7;
    localparam int TH_INIT  = 64;
    localparam int LOCK_CNT = 4;
    localparam int PERIOD   = (1 << PWM_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    agc_loop_if #(.D_WID(D_WID)) smp ();

    logic             agc_en, pwm_inv, pwm_th_ena;
    logic [1:0]       pwr_est_prd, pwm_step;
    logic [7:0]       pwr_target;
    logic [3:0]       pwr_tol;
    logic [PWM_W-1:0] pwm_th_in, pwm_max_val;
    logic [7:0]       pwr_est_val;
    logic             pwr_est_end, agc_fix, pwm_out;
    logic [PWM_W-1:0] pwm_th_out;

    agc_loop #(.D_WID(D_WID), .PWM_W(PWM_W), .TH_INIT(TH_INIT), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .reset_n(reset_n), .smp(smp),
        .agc_en(agc_en), .pwr_est_prd(pwr_est_prd), .pwr_target(pwr_target),
        .pwr_tol(pwr_tol), .pwm_step(pwm_step), .pwm_inv(pwm_inv),
        .pwm_th_ena(pwm_th_ena), .pwm_th_in(pwm_th_in), .pwm_max_val(pwm_max_val),
        .pwr_est_val(pwr_est_val), .pwr_est_end(pwr_est_end), .agc_fix(agc_fix),
        .pwm_th_out(pwm_th_out), .pwm_out(pwm_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, advanced once per clock edge.
    longint m_sum;
    int m_cnt, m_prd, m_pend, m_pend_due, m_pend_val, m_edge;
    int m_lock, m_pcnt, m_th_act;
    int e_val, e_end, e_fix, e_th, e_pwm;
    int hi_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int est_of(input longint avg);
        int k;
        if (avg == 0) return 0;
        k = 0;
        while ((avg >> (k + 1)) != 0) k++;
        return 8 * k + int'(((avg << 3) >> k) & 7);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_edge();
        int old_th, old_end, old_val, hi, lo, st, mx, p, win;
        if (!reset_n) begin
            m_sum = 0; m_cnt = 0; m_prd = 0; m_pend = 0; m_edge = 0;
            m_lock = 0; m_pcnt = 0; m_th_act = 0;
            e_val = 0; e_end = 0; e_fix = 0; e_th = TH_INIT; e_pwm = 0;
            return;
        end
        old_th = e_th; old_end = e_end; old_val = e_val;
        mx = int'(pwm_max_val);
        // PWM period: compare with the threshold adopted at the last boundary.
        e_pwm = ((m_pcnt < m_th_act) ? 1 : 0) ^ int'(pwm_inv);
        if (m_pcnt == 0) m_th_act = old_th;
        m_pcnt = (m_pcnt + 1) % PERIOD;
        // Threshold loop.
        hi = imin(int'(pwr_target) + int'(pwr_tol), 255);
        lo = imax(int'(pwr_target) - int'(pwr_tol), 0);
        st = 1 << pwm_step;
        if (pwm_th_ena) begin
            e_th = imin(int'(pwm_th_in), mx); m_lock = 0; e_fix = 0;
        end else if (!agc_en) begin
            m_lock = 0; e_fix = 0;
            if (old_th > mx) e_th = mx;
        end else if (old_end != 0) begin
            if (old_val > hi) begin
                e_th = imax(old_th - st, 0); m_lock = 0; e_fix = 0;
            end else if (old_val < lo) begin
                e_th = imin(old_th + st, mx); m_lock = 0; e_fix = 0;
            end else begin
                m_lock++; e_fix = (m_lock >= LOCK_CNT) ? 1 : 0;
            end
        end else if (old_th > mx) begin
            e_th = mx;
        end
        // Estimator: window of valid samples, result three edges after the last one.
        e_end = 0;
        if (!agc_en) begin
            m_sum = 0; m_cnt = 0; m_pend = 0;
        end else begin
            if (m_pend != 0 && m_pend_due == m_edge) begin
                e_end = 1; e_val = m_pend_val; m_pend = 0;
            end
            if (smp.data_vld) begin
                if (m_cnt == 0) m_prd = int'(pwr_est_prd);
                p = int'(smp.data_i_in) * int'(smp.data_i_in) + int'(smp.data_q_in) * int'(smp.data_q_in);
                m_sum += p;
                m_cnt++;
                win = 1 << (6 + 2 * m_prd);
                if (m_cnt == win) begin
                    m_pend = 1; m_pend_due = m_edge + 3;
                    m_pend_val = est_of(m_sum >> (6 + 2 * m_prd));
                    m_sum = 0; m_cnt = 0;
                end
            end
        end
        m_edge++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("est_val", pwr_est_val, e_val);
        check("est_end", pwr_est_end, e_end);
        check("agc_fix", agc_fix, e_fix);
        check("th_out", pwm_th_out, e_th);
        check("pwm_out", pwm_out, e_pwm);
        hi_cnt += int'(pwm_out);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pulse(input string tag, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pwr_est_end && n < budget);
        check(tag, pwr_est_end, 1);
    endtask

    task automatic set_iq(input int i, input int q);
        smp.data_i_in = D_WID'(i);
        smp.data_q_in = D_WID'(q);
    endtask

    task automatic count_high(input string tag, input int n, input int exp);
        hi_cnt = 0;
        ticks(n);
        check(tag, hi_cnt, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, th0, amp;
        smp.data_vld = 1'b0; set_iq(64, 64);
        agc_en = 1'b0; pwr_est_prd = 2'd0; pwr_target = 8'd150; pwr_tol = 4'd2;
        pwm_step = 2'd2; pwm_inv = 1'b1; pwm_th_ena = 1'b0; pwm_th_in = '0;
        pwm_max_val = PWM_W'(100);
        hi_cnt = 0;

        // Reset: pwm_out reads 0 even with inversion on.
        reset_n = 1'b0;
        ticks(3);
        check("rst_pwm", pwm_out, 0);
        check("rst_th", pwm_th_out, TH_INIT);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rel_pwm_inv", pwm_out, 1);
        pwm_inv = 1'b0;

        // Estimate and slew toward a target above the reachable range.
        agc_en = 1'b1; smp.data_vld = 1'b1;
        wait_pulse("first_pulse", 200, n);
        check("first_latency", n, 67);
        check("est_64", pwr_est_val, 104);
        tick();
        check("slew_0", pwm_th_out, 68);
        for (int w = 1; w < 10; w++) begin
            wait_pulse("slew_pulse", 200, n);
            check("slew_spacing", n, 63);
            tick();
            check("slew_th", pwm_th_out, imin(68 + 4 * w, 100));
        end
        check("slew_nofix", agc_fix, 0);

        set_iq(-512, -512);
        wait_pulse("neg_p1", 200, n);
        wait_pulse("neg_p2", 200, n);
        check("est_neg512", pwr_est_val, 152);

        // Lock, then unlock with a stronger signal.
        pwr_target = 8'd104; pwr_tol = 4'd0; set_iq(64, 64);
        agc_en = 1'b0; tick(); agc_en = 1'b1;
        for (int w = 1; w <= 5; w++) begin
            wait_pulse("lock_pulse", 200, n);
            check("lock_val", pwr_est_val, 104);
            tick();
            check("lock_fix", agc_fix, (w >= LOCK_CNT) ? 1 : 0);
        end
        set_iq(128, 128);
        th0 = int'(pwm_th_out);
        wait_pulse("unlock_p1", 200, n);
        tick();
        check("unlock_fix", agc_fix, 0);
        check("unlock_th1", pwm_th_out, th0 - 4);
        wait_pulse("unlock_p2", 200, n);
        check("est_128", pwr_est_val, 120);
        tick();
        check("unlock_th2", pwm_th_out, th0 - 8);

        // Window length changed mid-window applies from the next window.
        agc_en = 1'b0; tick(); agc_en = 1'b1;
        ticks(20);
        pwr_est_prd = 2'd1;
        wait_pulse("prd_p1", 200, n);
        check("prd_old_len", n + 20, 67);
        wait_pulse("prd_p2", 400, n);
        check("prd_new_len", n, 256);
        ticks(30);
        pwr_est_prd = 2'd0;
        wait_pulse("prd_p3", 400, n);
        wait_pulse("prd_p4", 200, n);
        check("prd_back_len", n, 64);

        // Randomized segments, checked every cycle against the model.
        for (int seg = 0; seg < 6; seg++) begin
            agc_en = 1'b0; tick();
            pwr_est_prd = 2'($urandom_range(0, 1));
            pwr_target  = 8'($urandom_range(60, 170));
            pwr_tol     = 4'($urandom_range(0, 15));
            pwm_step    = 2'($urandom_range(0, 3));
            pwm_max_val = PWM_W'($urandom_range(20, 127));
            amp = int'($urandom_range(1, 500));
            agc_en = 1'b1;
            for (int c = 0; c < 420; c++) begin
                smp.data_vld = ($urandom_range(0, 3) != 0);
                set_iq(amp - 5 + int'($urandom_range(0, 10)), -amp + int'($urandom_range(0, 8)));
                if ($urandom_range(0, 99) == 0) pwm_inv = ~pwm_inv;
                tick();
            end
        end
        smp.data_vld = 1'b1; pwm_inv = 1'b0;

        // Manual override with clamp, then inversion.
        pwm_th_ena = 1'b1; pwm_th_in = PWM_W'(120); pwm_max_val = PWM_W'(100);
        ticks(2 * PERIOD + 3);
        check("ovr_th", pwm_th_out, 100);
        count_high("ovr_duty", PERIOD, 100);
        pwm_inv = 1'b1;
        count_high("ovr_duty_inv", PERIOD, 27);
        pwm_inv = 1'b0;

        // PWM boundaries and a mid-period threshold change.
        pwm_th_in = '0;
        ticks(2 * PERIOD);
        count_high("pwm_zero", PERIOD, 0);
        pwm_max_val = PWM_W'(127); pwm_th_in = PWM_W'(127);
        ticks(2 * PERIOD);
        count_high("pwm_full", PERIOD, PERIOD);
        n = 0;
        while (m_pcnt != 60 && n < 2 * PERIOD) begin
            tick();
            n++;
        end
        pwm_th_in = PWM_W'(20);
        count_high("pwm_mid_old", PERIOD - 60, PERIOD - 60);
        count_high("pwm_mid_new", PERIOD, 20);

        // Reset mid-window, then a full window before the next pulse.
        pwm_th_ena = 1'b0; pwr_est_prd = 2'd0; set_iq(64, 64);
        agc_en = 1'b0; tick(); agc_en = 1'b1;
        ticks(30);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_end", pwr_est_end, 0);
        check("mid_rst_val", pwr_est_val, 0);
        check("mid_rst_th", pwm_th_out, TH_INIT);
        check("mid_rst_pwm", pwm_out, 0);
        ticks(2);
        @(negedge clk);
        reset_n = 1'b1;
        wait_pulse("rst_pulse", 200, n);
        check("rst_latency", n, 67);

        // agc_en dropped while the window-end result is in flight.
        n = 0;
        while (!(m_pend != 0 && m_cnt == 0) && n < 200) begin
            tick();
            n++;
        end
        check("en_drop_align", m_pend != 0 && m_cnt == 0, 1);
        agc_en = 1'b0;
        hi_cnt = 0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n += int'(pwr_est_end);
        end
        check("en_drop_nopulse", n, 0);
        agc_en = 1'b1;
        wait_pulse("en_rise_pulse", 200, n);
        check("en_rise_latency", n, 67);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
